// File: rtl/decode_queue.sv
// MIPS decode queue: instructions are decoded at push time (class tag, extended
// immediate) and held in a DEPTH-entry in-order queue with valid/ready on both sides.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                instruction,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [5:0]                 opcode,
  output logic [4:0]                 rs,
  output logic [4:0]                 rt,
  output logic [4:0]                 rd,
  output logic [4:0]                 shamt,
  output logic [5:0]                 func,
  output logic [15:0]                imm,
  output logic [XLEN-1:0]            imm_ext,
  output logic [25:0]                jtarget,
  output logic [1:0]                 iclass,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]      instr;
    logic [1:0]       iclass;
    logic [XLEN-1:0]  imm_ext;
  } entry_t;

  // Raw field slices are free wiring; only class and extension are computed here.
  function automatic entry_t decode(input logic [31:0] i);
    entry_t e;
    e.instr = i;
    case (i[31:26])
      6'h00:        e.iclass = 2'd0;
      6'h02, 6'h03: e.iclass = 2'd2;
      default:      e.iclass = 2'd1;
    endcase
    case (i[31:26])
      6'h0C, 6'h0D, 6'h0E: e.imm_ext = XLEN'(i[15:0]);
      6'h0F:               e.imm_ext = XLEN'(i[15:0]) << (XLEN - 16);
      default:             e.imm_ext = XLEN'($signed(i[15:0]));
    endcase
    return e;
  endfunction

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   cnt;
  logic            push, pop;
  entry_t          head;

  assign in_ready  = (cnt < CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (flush) begin
      // Storage is left as-is; only the bookkeeping is dropped.
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= decode(instruction);
        wptr      <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head    = mem[rptr];
  assign opcode  = head.instr[31:26];
  assign rs      = head.instr[25:21];
  assign rt      = head.instr[20:16];
  assign rd      = head.instr[15:11];
  assign shamt   = head.instr[10:6];
  assign func    = head.instr[5:0];
  assign imm     = head.instr[15:0];
  assign jtarget = head.instr[25:0];
  assign imm_ext = head.imm_ext;
  assign iclass  = head.iclass;
  assign count   = cnt;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue with a word-level scoreboard checked at each pop.
module tb_decode_queue;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instruction;
  logic [5:0]  opcode, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] imm_ext;
  logic [25:0] jtarget;
  logic [1:0]  iclass;
  logic [2:0]  count;

  decode_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func), .imm(imm),
    .imm_ext(imm_ext), .jtarget(jtarget), .iclass(iclass), .count(count)
  );

  always #5 clk = ~clk;

  logic [31:0] sb [$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] ref_ext(input logic [31:0] w);
    logic [15:0] im;
    im = w[15:0];
    if (w[31:26] == 6'd12 || w[31:26] == 6'd13 || w[31:26] == 6'd14) return {16'h0000, im};
    if (w[31:26] == 6'd15) return {im, 16'h0000};
    return {{16{im[15]}}, im};
  endfunction

  function automatic logic [1:0] ref_cls(input logic [31:0] w);
    if (w[31:26] == 6'd0) return 2'd0;
    if (w[31:26] == 6'd2 || w[31:26] == 6'd3) return 2'd2;
    return 2'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=event-missing expected=event", tag);
  endtask

  task automatic chk_head(input logic [31:0] w);
    chk("head_opcode", opcode, w[31:26]);
    chk("head_rs", rs, w[25:21]);
    chk("head_rt", rt, w[20:16]);
    chk("head_rd", rd, w[15:11]);
    chk("head_shamt", shamt, w[10:6]);
    chk("head_func", func, w[5:0]);
    chk("head_imm", imm, w[15:0]);
    chk("head_jtarget", jtarget, w[25:0]);
    chk("head_iclass", iclass, ref_cls(w));
    chk("head_imm_ext", imm_ext, ref_ext(w));
  endtask

  // One clock: score the handshakes about to occur, then check state after the edge.
  task automatic tick();
    logic p, q;
    p = in_valid && in_ready;
    q = out_valid && out_ready;
    if (flush) sb.delete();
    else begin
      if (q) begin
        if (sb.size() == 0) fail_now("pop_empty");
        else chk_head(sb.pop_front());
      end
      if (p) sb.push_back(instruction);
    end
    @(posedge clk); #1;
    chk("count", count, sb.size());
    chk("out_valid", out_valid, (sb.size() != 0));
    chk("in_ready", in_ready, (sb.size() < 4));
  endtask

  task automatic push_word(input logic [31:0] w);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    instruction = w;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = in_ready;
      tick();
    end
    if (!acc) fail_now("push_timeout");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 40 && (sb.size() != 0 || out_valid); k++) tick();
    if (sb.size() != 0) fail_now("drain_timeout");
    out_ready = 1'b0;
  endtask

  logic [31:0] wrap_words [10] = '{32'h00221820, 32'h08000010, 32'h0C00ABCD, 32'h3128ABCD,
                                   32'h3528FFFF, 32'h3928F00F, 32'h3C08BEEF, 32'h8D09FFF0,
                                   32'h2128FFFF, 32'h00A63022};

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruction = '0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_opcode", opcode, 0);
    chk("rst_imm_ext", imm_ext, 0);
    chk("rst_jtarget", jtarget, 0);
    chk("rst_iclass", iclass, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // addi: sign-extended negative immediate, visible the cycle after the push
    out_ready = 1'b0;
    push_word(32'h2128FFFF);
    chk("addi_valid", out_valid, 1);
    chk("addi_opcode", opcode, 32'h08);
    chk("addi_rs", rs, 9);
    chk("addi_rt", rt, 8);
    chk("addi_iclass", iclass, 1);
    chk("addi_ext", imm_ext, 32'hFFFFFFFF);
    drain();

    // ori zero-extends, lui shifts into the top half
    push_word(32'h3528FFFF);
    push_word(32'h3C081234);
    chk("ori_ext", imm_ext, 32'h0000FFFF);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("lui_ext", imm_ext, 32'h12340000);
    drain();

    // R-type then J-type
    push_word(32'h00221820);
    push_word(32'h08000010);
    chk("add_iclass", iclass, 0);
    chk("add_rs", rs, 1);
    chk("add_rt", rt, 2);
    chk("add_rd", rd, 3);
    chk("add_shamt", shamt, 0);
    chk("add_func", func, 32'h20);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("j_iclass", iclass, 2);
    chk("j_target", jtarget, 32'h0000010);
    drain();

    // Fill to DEPTH, hold the fifth word, then release in order
    push_word(32'h20010001);
    push_word(32'h20020002);
    push_word(32'h20030003);
    push_word(32'h20040004);
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    in_valid = 1'b1; instruction = 32'h20050005;
    tick(); tick();
    chk("held_count", count, 4);
    out_ready = 1'b1;
    begin
      logic acc;
      acc = 1'b0;
      for (int k = 0; k < 10 && !acc; k++) begin
        acc = in_ready;
        tick();
      end
      if (!acc) fail_now("held_push_timeout");
    end
    in_valid = 1'b0;
    drain();

    // Back-to-back push+pop walks the pointers around several times
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      instruction = wrap_words[i];
      tick();
    end
    in_valid = 1'b0;
    drain();

    // Flush beats a same-cycle push and pop
    push_word(32'h11112222);
    push_word(32'h33334444);
    push_word(32'h55556666);
    chk("preflush_count", count, 3);
    flush = 1'b1; in_valid = 1'b1; instruction = 32'h77778888; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    tick();
    chk("postflush_count", count, 0);

    // Asynchronous reset between edges, mid-burst
    push_word(32'h2128FFFF);
    push_word(32'h3528FFFF);
    push_word(32'h3C081234);
    chk("preRst_count", count, 3);
    in_valid = 1'b1; instruction = 32'h00221820;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_opcode", opcode, 0);
    chk("arst_imm_ext", imm_ext, 0);
    chk("arst_iclass", iclass, 0);
    sb.delete();
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    push_word(32'h2128FFFF);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_ext", imm_ext, 32'hFFFFFFFF);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
